pdpu_shift_arbiter: RTL

//  Shares one logical shifter (barrel_shifter, left and right instances) between NUM_REQ

---
 rtl/pdpu_shift_arbiter_pkg.sv | 24 ++
 rtl/pdpu_shift_arbiter_barrel_shifter.sv | 45 ++++
 rtl/pdpu_shift_arbiter.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/pdpu_shift_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module : pdpu_shift_pkg
// Purpose: Shared types and helpers for the PDPU shift arbiter slice.
//          - shift_dir_e : logical shift direction encoding used on req_dir_i
//          - id_width()  : width of a requester index for a given count
// Config : PDPU_SHIFT_STICKY_EN (used by pdpu_shift_arbiter, not here)
// Rev    : 1.0  initial release
// ============================================================================
package pdpu_shift_pkg;

  typedef enum logic {
    SHIFT_LEFT  = 1'b0,
    SHIFT_RIGHT = 1'b1
  } shift_dir_e;

  // A single requester still needs one bit so the id port never collapses
  // to zero width.
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage : pdpu_shift_pkg
`default_nettype wire

// File: rtl/pdpu_shift_arbiter_barrel_shifter.sv
`default_nettype none
// ============================================================================
// Module : barrel_shifter
// Purpose: Zero-filling logarithmic barrel shifter, one direction per instance.
//          MODE = 0 : logical left shift
//          MODE = 1 : logical right shift
// Ports  : operand_i  in  WIDTH        value to shift
//          amount_i   in  SHIFT_WIDTH  shift amount (0 .. 2**SHIFT_WIDTH-1)
//          result_o   out WIDTH        shifted value
// Config : none
// Rev    : 1.0  initial release
// ============================================================================
module barrel_shifter
  import pdpu_shift_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int SHIFT_WIDTH = 3,
  parameter int MODE        = 0
) (
  input  logic [WIDTH-1:0]       operand_i,
  input  logic [SHIFT_WIDTH-1:0] amount_i,
  output logic [WIDTH-1:0]       result_o
);

  // w_stage[s] is the operand after the amount bits below s have been applied.
  logic [WIDTH-1:0] w_stage [0:SHIFT_WIDTH];

  assign w_stage[0] = operand_i;

  for (genvar s = 0; s < SHIFT_WIDTH; s++) begin : g_stage
    if ((2 ** s) >= WIDTH) begin : g_flush
      // A stage that moves by WIDTH or more clears the word in either mode;
      // this is what makes amt >= WIDTH yield zero.
      assign w_stage[s+1] = amount_i[s] ? '0 : w_stage[s];
    end else if (MODE == 0) begin : g_left
      assign w_stage[s+1] = amount_i[s] ? (w_stage[s] << (2 ** s)) : w_stage[s];
    end else begin : g_right
      assign w_stage[s+1] = amount_i[s] ? (w_stage[s] >> (2 ** s)) : w_stage[s];
    end
  end

  assign result_o = w_stage[SHIFT_WIDTH];

endmodule : barrel_shifter
`default_nettype wire

// File: rtl/pdpu_shift_arbiter.sv
`default_nettype none
// ============================================================================
// Module : pdpu_shift_arbiter
// Purpose: Round-robin sharing of one logical shifter between NUM_REQ
//          requesters, valid/ready on both sides, one registered output stage.
// Ports  : clk_i          in   clock, rising edge
//          rst_ni         in   synchronous active-low reset
//          req_valid_i    in   [NUM_REQ]            request valid
//          req_ready_o    out  [NUM_REQ]            request accept (one-hot/zero)
//          req_operand_i  in   [NUM_REQ*WIDTH]      operands, requester k at k*WIDTH
//          req_amount_i   in   [NUM_REQ*SHIFT_WIDTH] amounts, requester k at k*SHIFT_WIDTH
//          req_dir_i      in   [NUM_REQ]            0 = left, 1 = right
//          rsp_valid_o    out  response valid
//          rsp_ready_i    in   downstream accepts response
//          rsp_result_o   out  [WIDTH]              shifted operand
//          rsp_id_o       out  [ID_W]               granted requester index
//          rsp_sticky_o   out  OR of bits lost on a right shift
// Config : PDPU_SHIFT_STICKY_EN - when defined, rsp_sticky_o is computed and
//          registered; otherwise it is tied to 0.
// Rev    : 1.0  initial release
// ============================================================================
module pdpu_shift_arbiter
  import pdpu_shift_pkg::*;
#(
  parameter  int WIDTH       = 8,
  parameter  int SHIFT_WIDTH = 3,
  parameter  int NUM_REQ     = 4,
  localparam int ID_W        = id_width(NUM_REQ)
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic [NUM_REQ-1:0]             req_valid_i,
  output logic [NUM_REQ-1:0]             req_ready_o,
  input  logic [NUM_REQ*WIDTH-1:0]       req_operand_i,
  input  logic [NUM_REQ*SHIFT_WIDTH-1:0] req_amount_i,
  input  logic [NUM_REQ-1:0]             req_dir_i,
  output logic                           rsp_valid_o,
  input  logic                           rsp_ready_i,
  output logic [WIDTH-1:0]               rsp_result_o,
  output logic [ID_W-1:0]                rsp_id_o,
  output logic                           rsp_sticky_o
);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic             rsp_valid_q,  rsp_valid_d;
  logic [WIDTH-1:0] rsp_result_q, rsp_result_d;
  logic [ID_W-1:0]  rsp_id_q,     rsp_id_d;
  logic [ID_W-1:0]  rr_ptr_q,     rr_ptr_d;

  // --------------------------------------------------------------------------
  // Arbitration
  // --------------------------------------------------------------------------
  logic               w_accept;
  logic               w_found;
  logic               w_fire;
  logic [ID_W-1:0]    w_idx;
  logic [ID_W:0]      w_cand;
  logic [NUM_REQ-1:0] w_grant;

  // The output register can take a new value when empty or draining now.
  assign w_accept = !rsp_valid_q || rsp_ready_i;

  // Scan from rr_ptr upward with wrap. w_cand carries one extra bit so the
  // sum rr_ptr + i (at most 2*NUM_REQ-2) never overflows before the wrap.
  always_comb begin
    w_found = 1'b0;
    w_idx   = '0;
    w_cand  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_cand = {1'b0, rr_ptr_q} + (ID_W+1)'(i);
      if (w_cand >= (ID_W+1)'(NUM_REQ)) begin
        w_cand = w_cand - (ID_W+1)'(NUM_REQ);
      end
      if (!w_found && req_valid_i[w_cand[ID_W-1:0]]) begin
        w_found = 1'b1;
        w_idx   = w_cand[ID_W-1:0];
      end
    end
  end

  always_comb begin
    w_grant = '0;
    if (w_found) begin
      w_grant[w_idx] = 1'b1;
    end
  end

  assign req_ready_o = w_grant & {NUM_REQ{w_accept}};
  assign w_fire      = w_found && w_accept;

  // --------------------------------------------------------------------------
  // Granted payload and shifters
  // --------------------------------------------------------------------------
  logic [WIDTH-1:0]       w_sel_operand;
  logic [SHIFT_WIDTH-1:0] w_sel_amount;
  shift_dir_e             w_sel_dir;
  logic [WIDTH-1:0]       w_shl_result;
  logic [WIDTH-1:0]       w_shr_result;
  logic [WIDTH-1:0]       w_shift_result;

  assign w_sel_operand = req_operand_i[w_idx*WIDTH +: WIDTH];
  assign w_sel_amount  = req_amount_i[w_idx*SHIFT_WIDTH +: SHIFT_WIDTH];
  assign w_sel_dir     = shift_dir_e'(req_dir_i[w_idx]);

  barrel_shifter #(
    .WIDTH       (WIDTH),
    .SHIFT_WIDTH (SHIFT_WIDTH),
    .MODE        (0)
  ) u_shift_left (
    .operand_i (w_sel_operand),
    .amount_i  (w_sel_amount),
    .result_o  (w_shl_result)
  );

  barrel_shifter #(
    .WIDTH       (WIDTH),
    .SHIFT_WIDTH (SHIFT_WIDTH),
    .MODE        (1)
  ) u_shift_right (
    .operand_i (w_sel_operand),
    .amount_i  (w_sel_amount),
    .result_o  (w_shr_result)
  );

  assign w_shift_result = (w_sel_dir == SHIFT_RIGHT) ? w_shr_result : w_shl_result;

  // --------------------------------------------------------------------------
  // Next state
  // --------------------------------------------------------------------------
  always_comb begin
    rsp_valid_d  = rsp_valid_q;
    rsp_result_d = rsp_result_q;
    rsp_id_d     = rsp_id_q;
    rr_ptr_d     = rr_ptr_q;
    if (w_fire) begin
      rsp_valid_d  = 1'b1;
      rsp_result_d = w_shift_result;
      rsp_id_d     = w_idx;
      rr_ptr_d     = (w_idx == ID_W'(NUM_REQ - 1)) ? '0 : w_idx + ID_W'(1);
    end else if (rsp_ready_i) begin
      rsp_valid_d  = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rsp_valid_q  <= 1'b0;
      rsp_result_q <= '0;
      rsp_id_q     <= '0;
      rr_ptr_q     <= '0;
    end else begin
      rsp_valid_q  <= rsp_valid_d;
      rsp_result_q <= rsp_result_d;
      rsp_id_q     <= rsp_id_d;
      rr_ptr_q     <= rr_ptr_d;
    end
  end

  assign rsp_valid_o  = rsp_valid_q;
  assign rsp_result_o = rsp_result_q;
  assign rsp_id_o     = rsp_id_q;

  // --------------------------------------------------------------------------
  // Sticky bit
  // --------------------------------------------------------------------------
`ifdef PDPU_SHIFT_STICKY_EN
  logic             rsp_sticky_q, rsp_sticky_d;
  logic [WIDTH-1:0] w_sticky_mask;
  logic             w_sticky;

  // Mask of the low amt bits, i.e. exactly the bits a right shift discards;
  // an amount reaching WIDTH discards the whole operand.
  always_comb begin
    w_sticky_mask = (WIDTH'(1) << w_sel_amount) - WIDTH'(1);
    if (32'(w_sel_amount) >= WIDTH) begin
      w_sticky_mask = '1;
    end
  end

  assign w_sticky = (w_sel_dir == SHIFT_RIGHT) && (|(w_sel_operand & w_sticky_mask));

  always_comb begin
    rsp_sticky_d = rsp_sticky_q;
    if (w_fire) begin
      rsp_sticky_d = w_sticky;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rsp_sticky_q <= 1'b0;
    end else begin
      rsp_sticky_q <= rsp_sticky_d;
    end
  end

  assign rsp_sticky_o = rsp_sticky_q;
`else
  assign rsp_sticky_o = 1'b0;
`endif

endmodule : pdpu_shift_arbiter
`default_nettype wire
